// File: rtl/ps2_kbd_pkg.sv
// Shared constants for the PS/2 keyboard controller: scan codes, key indices, FSM states.
package ps2_kbd_pkg;

  localparam logic [7:0] SC_E0      = 8'hE0;
  localparam logic [7:0] SC_F0      = 8'hF0;
  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] SC_ACK     = 8'hFA;
  localparam logic [7:0] SC_BAT_OK  = 8'hAA;
  localparam logic [7:0] SC_BAT_ERR = 8'hFC;
  localparam logic [7:0] SC_RESEND  = 8'hFE;

  localparam logic [7:0] SC_UP      = 8'h1D;
  localparam logic [7:0] SC_DOWN    = 8'h1B;
  localparam logic [7:0] SC_LEFT    = 8'h1C;
  localparam logic [7:0] SC_RIGHT   = 8'h23;
  localparam logic [7:0] SC_FIRE    = 8'h29;
  localparam logic [7:0] SC_FIRE2   = 8'h5A;
  localparam logic [7:0] SC_UP2     = 8'h75;
  localparam logic [7:0] SC_DOWN2   = 8'h72;
  localparam logic [7:0] SC_LEFT2   = 8'h6B;
  localparam logic [7:0] SC_RIGHT2  = 8'h74;

  localparam int NUM_KEYS = 10;

  localparam logic [3:0] KEY_UP     = 4'd0;
  localparam logic [3:0] KEY_DOWN   = 4'd1;
  localparam logic [3:0] KEY_LEFT   = 4'd2;
  localparam logic [3:0] KEY_RIGHT  = 4'd3;
  localparam logic [3:0] KEY_FIRE   = 4'd4;
  localparam logic [3:0] KEY_UP2    = 4'd5;
  localparam logic [3:0] KEY_DOWN2  = 4'd6;
  localparam logic [3:0] KEY_LEFT2  = 4'd7;
  localparam logic [3:0] KEY_RIGHT2 = 4'd8;
  localparam logic [3:0] KEY_FIRE2  = 4'd9;

  typedef enum logic [2:0] {
    SEND_RST,
    WAIT_SENT,
    WAIT_ACK,
    WAIT_BAT,
    RUN,
    FAIL
  } kbd_state_e;

endpackage

// File: rtl/ps2_scan_map.sv
// Combinational (ext, code) -> key index lookup; codes only match under their own ext value.
module ps2_scan_map
  import ps2_kbd_pkg::*;
(
  input  logic       ext_i,
  input  logic [7:0] code_i,
  output logic       hit_o,
  output logic [3:0] index_o
);

  always_comb begin
    hit_o   = 1'b1;
    index_o = KEY_UP;
    if (!ext_i) begin
      case (code_i)
        SC_UP:    index_o = KEY_UP;
        SC_DOWN:  index_o = KEY_DOWN;
        SC_LEFT:  index_o = KEY_LEFT;
        SC_RIGHT: index_o = KEY_RIGHT;
        SC_FIRE:  index_o = KEY_FIRE;
        SC_FIRE2: index_o = KEY_FIRE2;
        default:  hit_o   = 1'b0;
      endcase
    end else begin
      case (code_i)
        SC_UP2:    index_o = KEY_UP2;
        SC_DOWN2:  index_o = KEY_DOWN2;
        SC_LEFT2:  index_o = KEY_LEFT2;
        SC_RIGHT2: index_o = KEY_RIGHT2;
        default:   hit_o   = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keyboard_ctrl.sv
// PS/2 keyboard bring-up (reset command, ACK, BAT with retries) and scan-code decode to key levels/pulses.
module ps2_keyboard_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int ACK_TIMEOUT = 2_500_000,
  parameter int BAT_TIMEOUT = 50_000_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  output logic [7:0]          ps2_command,
  output logic                ps2_send,
  input  logic                ps2_send_done,
  input  logic                ps2_send_error,
  input  logic [7:0]          ps2_data,
  input  logic                ps2_data_valid,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic                init_done,
  output logic                init_fail
);

  localparam int TMO_MAX = (BAT_TIMEOUT > ACK_TIMEOUT) ? BAT_TIMEOUT : ACK_TIMEOUT;
  localparam int TMO_W   = $clog2(TMO_MAX) + 1;
  localparam int ATT_W   = $clog2(MAX_RETRY + 1);

  kbd_state_e          state_q, state_d;
  logic [ATT_W-1:0]    attempt_q, attempt_d, attempt_inc;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                ext_q, ext_d, brk_q, brk_d;
  logic [NUM_KEYS-1:0] held_q, held_d, press_q, press_d;
  logic                send_q, send_d;
  logic [7:0]          cmd_q, cmd_d;
  logic                retry, decode_en, in_wait;
  logic                map_hit;
  logic [3:0]          map_index;
  logic [NUM_KEYS-1:0] key_sel;

  ps2_scan_map u_map (
    .ext_i   (ext_q),
    .code_i  (ps2_data),
    .hit_o   (map_hit),
    .index_o (map_index)
  );

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_sel
    assign key_sel[gi] = map_hit && (map_index == 4'(gi));
  end

  assign attempt_inc = attempt_q + ATT_W'(1);
  assign decode_en   = (state_q == RUN) || (state_q == FAIL);
  assign in_wait     = (state_q == WAIT_ACK) || (state_q == WAIT_BAT);

  always_comb begin
    state_d   = state_q;
    attempt_d = attempt_q;
    retry     = 1'b0;
    send_d    = 1'b0;
    cmd_d     = cmd_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    held_d    = held_q;
    press_d   = '0;

    case (state_q)
      SEND_RST: begin
        send_d  = 1'b1;
        cmd_d   = CMD_RESET;
        state_d = WAIT_SENT;
      end
      WAIT_SENT: begin
        if (ps2_send_done)       state_d = WAIT_ACK;
        else if (ps2_send_error) retry   = 1'b1;
      end
      WAIT_ACK: begin
        if (ps2_data_valid && ps2_data == SC_ACK)      state_d = WAIT_BAT;
        else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1))     retry   = 1'b1;
      end
      WAIT_BAT: begin
        if (ps2_data_valid && ps2_data == SC_BAT_OK)       state_d = RUN;
        else if (ps2_data_valid && ps2_data == SC_BAT_ERR) retry   = 1'b1;
        else if (tmo_q == TMO_W'(BAT_TIMEOUT - 1))         retry   = 1'b1;
      end
      default: ;
    endcase

    if (retry) begin
      attempt_d = attempt_inc;
      state_d   = (attempt_inc < ATT_W'(MAX_RETRY)) ? SEND_RST : FAIL;
    end

    // Hot-plug BAT and stray ACK/RESEND are only special once the keyboard is up.
    if (decode_en && ps2_data_valid) begin
      if (state_q == RUN && ps2_data == SC_BAT_OK) begin
        held_d = '0;
        ext_d  = 1'b0;
        brk_d  = 1'b0;
      end else if (state_q == RUN && (ps2_data == SC_ACK || ps2_data == SC_RESEND)) begin
        held_d = held_q;
      end else if (ps2_data == SC_E0) begin
        ext_d = 1'b1;
      end else if (ps2_data == SC_F0) begin
        brk_d = 1'b1;
      end else begin
        held_d  = brk_q ? (held_q & ~key_sel) : (held_q | key_sel);
        press_d = brk_q ? '0 : (key_sel & ~held_q);
        ext_d   = 1'b0;
        brk_d   = 1'b0;
      end
    end
  end

  assign tmo_d = (state_d != state_q || !in_wait) ? '0 : tmo_q + TMO_W'(1);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= SEND_RST;
      attempt_q <= '0;
      tmo_q     <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      held_q    <= '0;
      press_q   <= '0;
      send_q    <= 1'b0;
      cmd_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      attempt_q <= attempt_d;
      tmo_q     <= tmo_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      held_q    <= held_d;
      press_q   <= press_d;
      send_q    <= send_d;
      cmd_q     <= cmd_d;
    end
  end

  assign ps2_command = cmd_q;
  assign ps2_send    = send_q;
  assign key_held    = held_q;
  assign key_press   = press_q;
  assign init_done   = (state_q == RUN);
  assign init_fail   = (state_q == FAIL);

endmodule

// File: tb/tb_ps2_keyboard_ctrl.sv
// Directed bench: init handshake with a BAT-error retry, table of scan-code vectors, mid-prefix reset, timeout/fail path.
module tb_ps2_keyboard_ctrl;

  localparam int ACK_TO = 100;
  localparam int BAT_TO = 200;
  localparam int MAXR   = 3;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ps2_command;
  logic       ps2_send;
  logic       ps2_send_done = 1'b0;
  logic       ps2_send_error = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_data_valid = 1'b0;
  logic [9:0] key_held, key_press;
  logic       init_done, init_fail;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] b;
    logic [9:0] held;
    logic [9:0] press;
  } vec_t;

  vec_t vt[$];

  ps2_keyboard_ctrl #(
    .ACK_TIMEOUT (ACK_TO),
    .BAT_TIMEOUT (BAT_TO),
    .MAX_RETRY   (MAXR)
  ) dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .ps2_command    (ps2_command),
    .ps2_send       (ps2_send),
    .ps2_send_done  (ps2_send_done),
    .ps2_send_error (ps2_send_error),
    .ps2_data       (ps2_data),
    .ps2_data_valid (ps2_data_valid),
    .key_held       (key_held),
    .key_press      (key_press),
    .init_done      (init_done),
    .init_fail      (init_fail)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK_50);
  endtask

  // Caller sits on a negedge; on return the registered outputs reflect the byte.
  task automatic send_byte(input logic [7:0] b);
    ps2_data       = b;
    ps2_data_valid = 1'b1;
    @(negedge CLOCK_50);
    ps2_data_valid = 1'b0;
  endtask

  task automatic pulse_done();
    ps2_send_done = 1'b1;
    @(negedge CLOCK_50);
    ps2_send_done = 1'b0;
  endtask

  task automatic wait_send(input string name);
    int cyc;
    cyc = 0;
    while (ps2_send !== 1'b1 && cyc < 50) begin
      @(negedge CLOCK_50);
      cyc++;
    end
    check(name, 32'(ps2_send), 32'd1);
    $display("send pulse %s after %0d cycles, command %h", name, cyc, ps2_command);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_held"}, 32'(key_held), 32'd0);
    check({tag, "_press"}, 32'(key_press), 32'd0);
    check({tag, "_send"}, 32'(ps2_send), 32'd0);
    check({tag, "_cmd"}, 32'(ps2_command), 32'd0);
    check({tag, "_done"}, 32'(init_done), 32'd0);
    check({tag, "_fail"}, 32'(init_fail), 32'd0);
  endtask

  initial begin
    int pulses;
    int t_pulse[$];

    vt.push_back('{b: 8'h1D, held: 10'h001, press: 10'h001});
    vt.push_back('{b: 8'h1D, held: 10'h001, press: 10'h000});
    vt.push_back('{b: 8'hF0, held: 10'h001, press: 10'h000});
    vt.push_back('{b: 8'h1D, held: 10'h000, press: 10'h000});
    vt.push_back('{b: 8'hE0, held: 10'h000, press: 10'h000});
    vt.push_back('{b: 8'h75, held: 10'h020, press: 10'h020});
    vt.push_back('{b: 8'h75, held: 10'h020, press: 10'h000});
    vt.push_back('{b: 8'hE0, held: 10'h020, press: 10'h000});
    vt.push_back('{b: 8'hF0, held: 10'h020, press: 10'h000});
    vt.push_back('{b: 8'h75, held: 10'h000, press: 10'h000});
    vt.push_back('{b: 8'hE0, held: 10'h000, press: 10'h000});
    vt.push_back('{b: 8'h1D, held: 10'h000, press: 10'h000});
    vt.push_back('{b: 8'h1D, held: 10'h001, press: 10'h001});
    vt.push_back('{b: 8'h29, held: 10'h011, press: 10'h010});
    vt.push_back('{b: 8'h5A, held: 10'h211, press: 10'h200});
    vt.push_back('{b: 8'h1B, held: 10'h213, press: 10'h002});
    vt.push_back('{b: 8'hE0, held: 10'h213, press: 10'h000});
    vt.push_back('{b: 8'h72, held: 10'h253, press: 10'h040});
    vt.push_back('{b: 8'hE0, held: 10'h253, press: 10'h000});
    vt.push_back('{b: 8'h6B, held: 10'h2D3, press: 10'h080});
    vt.push_back('{b: 8'hFA, held: 10'h2D3, press: 10'h000});
    vt.push_back('{b: 8'hFE, held: 10'h2D3, press: 10'h000});
    vt.push_back('{b: 8'hE0, held: 10'h2D3, press: 10'h000});
    vt.push_back('{b: 8'h74, held: 10'h3D3, press: 10'h100});
    vt.push_back('{b: 8'hF0, held: 10'h3D3, press: 10'h000});
    vt.push_back('{b: 8'h29, held: 10'h3C3, press: 10'h000});
    vt.push_back('{b: 8'h1C, held: 10'h3C7, press: 10'h004});
    vt.push_back('{b: 8'hAA, held: 10'h000, press: 10'h000});
    vt.push_back('{b: 8'hE0, held: 10'h000, press: 10'h000});
    vt.push_back('{b: 8'hF0, held: 10'h000, press: 10'h000});
    vt.push_back('{b: 8'hAA, held: 10'h000, press: 10'h000});
    vt.push_back('{b: 8'h1C, held: 10'h004, press: 10'h004});

    // Reset state
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;

    // Init with one BAT-error retry, then a clean pass
    wait_send("send1");
    check("send1_cmd", 32'(ps2_command), 32'hFF);
    tick();
    check("send1_one_cycle", 32'(ps2_send), 32'd0);
    pulse_done();
    send_byte(8'h1D);
    check("wait_ack_ignores_code", 32'(key_held), 32'd0);
    send_byte(8'hFA);
    check("wait_bat_not_done", 32'(init_done), 32'd0);
    send_byte(8'hFC);
    wait_send("send2");
    check("send2_cmd", 32'(ps2_command), 32'hFF);
    tick();
    pulse_done();
    send_byte(8'hFA);
    check("pre_bat_done", 32'(init_done), 32'd0);
    send_byte(8'hAA);
    check("init_done", 32'(init_done), 32'd1);
    check("init_not_fail", 32'(init_fail), 32'd0);
    check("run_held_clear", 32'(key_held), 32'd0);

    // Table-driven decode vectors
    foreach (vt[i]) begin
      send_byte(vt[i].b);
      $display("vec %0d byte %h held %h press %h", i, vt[i].b, key_held, key_press);
      check($sformatf("vec%0d_held", i), 32'(key_held), 32'(vt[i].held));
      check($sformatf("vec%0d_press", i), 32'(key_press), 32'(vt[i].press));
    end

    // Reset in the middle of an E0 F0 prefix with a key held
    send_byte(8'hE0);
    send_byte(8'hF0);
    reset = 1'b1;
    tick();
    tick();
    check_all_zero("midreset");
    reset = 1'b0;
    wait_send("send3");
    tick();
    pulse_done();
    send_byte(8'hFA);
    send_byte(8'hAA);
    check("reinit_done", 32'(init_done), 32'd1);
    send_byte(8'h1D);
    check("post_reset_make_held", 32'(key_held), 32'h001);
    check("post_reset_make_press", 32'(key_press), 32'h001);
    send_byte(8'h75);
    check("post_reset_plain75", 32'(key_held), 32'h001);

    // Timeout path: send error, then two ACK timeouts -> FAIL after 3 attempts
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    pulses = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      ps2_send_done  = 1'b0;
      ps2_send_error = 1'b0;
      if (ps2_send === 1'b1) begin
        pulses++;
        t_pulse.push_back(cyc);
        $display("retry pulse %0d at cycle %0d", pulses, cyc);
        if (pulses == 1) ps2_send_error = 1'b1;
        else             ps2_send_done  = 1'b1;
      end
      @(negedge CLOCK_50);
    end
    ps2_send_done  = 1'b0;
    ps2_send_error = 1'b0;
    check("retry_pulse_count", 32'(pulses), 32'(MAXR));
    if (t_pulse.size() >= 3) begin
      check("err_retry_quick", 32'(t_pulse[1] - t_pulse[0] < 10), 32'd1);
      check("ack_timeout_gap", 32'(t_pulse[2] - t_pulse[1] >= ACK_TO && t_pulse[2] - t_pulse[1] <= ACK_TO + 5), 32'd1);
    end else begin
      check("retry_pulse_times", 32'(t_pulse.size()), 32'd3);
    end
    check("init_fail", 32'(init_fail), 32'd1);
    check("fail_not_done", 32'(init_done), 32'd0);
    send_byte(8'h29);
    check("fail_fire_held", 32'(key_held), 32'h010);
    check("fail_fire_press", 32'(key_press), 32'h010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_ctrl.md
PS2_KEYBOARD_CTRL -- requirements
Module: ps2_keyboard_ctrl

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 2_500_000, meaning cycles to wait for 0xFA after a command is sent (50 ms).
REQ-002 SHALL have parameter BAT_TIMEOUT, default 50_000_000, meaning cycles to wait for 0xAA after ACK (1 s).
REQ-003 SHALL have parameter MAX_RETRY, default 3, meaning reset-command attempts before entering FAIL.
REQ-004 Port: CLOCK_50  in  1  system clock; reset  in  1  reset, synchronous, active-high.
REQ-005 Port: ps2_command  out  8  byte to PS2_Controller.the_command.
REQ-006 Port: ps2_send  out  1  one-cycle send request to PS2_Controller.send_command.
REQ-007 Port: ps2_send_done  in  1  command_was_sent; ps2_send_error  in  1  error_communication_timed_out.
REQ-008 Port: ps2_data  in  8  received byte; ps2_data_valid  in  1  one-cycle received-byte strobe.
REQ-009 Port: key_held  out  10  level per key; bit order {fire2,right2,left2,down2,up2,fire,right,left,down,up}, bit 0 = up.
REQ-010 Port: key_press  out  10  one-cycle pulse on the released-to-held transition, same bit order.
REQ-011 Port: init_done  out  1  high in RUN; init_fail  out  1  high in FAIL.

Function
REQ-012 FSM states: SEND_RST, WAIT_SENT, WAIT_ACK, WAIT_BAT, RUN, FAIL.
REQ-013 SEND_RST: drive ps2_command=0xFF, pulse ps2_send for exactly one cycle, go to WAIT_SENT.
REQ-014 WAIT_SENT: on ps2_send_done go to WAIT_ACK; on ps2_send_error, retry.
REQ-015 WAIT_ACK: byte 0xFA goes to WAIT_BAT; any other byte is ignored; ACK_TIMEOUT expiry retries.
REQ-016 WAIT_BAT: byte 0xAA goes to RUN; byte 0xFC retries; other bytes are ignored; BAT_TIMEOUT expiry retries.
REQ-017 Retry: increment attempt count; if count < MAX_RETRY go to SEND_RST, otherwise go to FAIL.
REQ-018 The timeout counter SHALL clear on every state entry and count every cycle while in WAIT_ACK or WAIT_BAT; expiry is count == TIMEOUT-1.
REQ-019 Scan decoding SHALL be active in RUN and FAIL only; bytes received in other states never change key_held.
REQ-020 Byte 0xE0 sets the ext flag; byte 0xF0 sets the brk flag; neither byte alters keys.
REQ-021 Any other byte is a code: look up (ext, code); on a match, set the key when brk=0 and clear it when brk=1; clear ext and brk after every code byte, matched or not.
REQ-022 Map, ext=0: 1D up, 1B down, 1C left, 23 right, 29 fire, 5A fire2.
REQ-023 Map, ext=1: 75 up2, 72 down2, 6B left2, 74 right2; a code with the wrong ext value never matches.
REQ-024 key_press[i] SHALL be high for one cycle, the cycle after the code byte, only if key_held[i] was 0; typematic repeats produce no pulse.
REQ-025 In RUN, byte 0xAA (hot-plug BAT) SHALL clear key_held and the ext/brk flags; in RUN, bytes 0xFA and 0xFE SHALL be ignored.
REQ-026 Decode latency: key_held updates on the cycle after the ps2_data_valid that carries the code byte.

Reset
REQ-027 Reset SHALL force: state=SEND_RST, attempt count=0, timeout counter=0, ext=0, brk=0.
REQ-028 Reset SHALL force outputs: key_held=0, key_press=0, ps2_send=0, ps2_command=0x00, init_done=0, init_fail=0.
REQ-029 Reset asserted mid-handshake or mid-prefix SHALL abandon the sequence; the first cycle after reset deasserts SHALL be SEND_RST.

Structure
REQ-030 Package ps2_kbd_pkg SHALL hold: scan-code constants (E0, F0, FF, FA, AA, FC, FE, key codes), key-index constants 0..9, and the FSM state enum.
REQ-031 Sub-module ps2_scan_map SHALL be a combinational lookup (ext, code) -> {hit, index[3:0]}; all sequencing stays in ps2_keyboard_ctrl.

Verification
REQ-032 Normal init: release reset; send_done, FA, AA -> one ps2_send pulse with command FF; init_done=1 after AA.
REQ-033 Make/break: in RUN, feed 1D, 1D, F0 1D -> key_held[0] high after first 1D; single key_press[0] pulse; key_held[0]=0 after F0 1D.
REQ-034 Extended keys: feed E0 75 then 75 -> up2 held after E0 75; plain 75 does not change up2; E0 F0 75 clears up2.
REQ-035 Retry/fail (ACK_TIMEOUT=100, MAX_RETRY=3): never send FA -> exactly 3 ps2_send pulses spaced by timeouts; init_fail=1; a later 29 still sets fire.
REQ-036 Hot-plug: keys 1C and E0 74 held, then AA -> key_held=0; prefix state cleared (next 1C is treated as make).
REQ-037 Reset mid-sequence: assert reset after E0 F0 with key_held nonzero -> all outputs zero; the following 75 is not treated as extended break.
